// File: rtl/uart_loader_pkg.sv
// Shared state types and baud-rate helper for the UART boot loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE,
    S_ERROR
  } loaderState_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rxState_e;

  function automatic int unsigned clks_per_bit(input int unsigned clkFreq,
                                               input int unsigned baud);
    return clkFreq / baud;
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Memory write bus and CPU-control status driven by the boot loader.
interface uart_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport master (
    output mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

  modport slave (
    input mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

endinterface

// File: rtl/uart_loader_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer; emits one-cycle
// rx_valid or rx_ferr pulses after each stop-bit sample.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  rxState_e      r_state;
  rxState_e      w_nextState;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_rxPrev;
  logic [CW-1:0] r_clkCnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic          w_rx;
  logic          w_bitTick;
  logic          w_halfTick;

  assign w_rx       = r_sync2;
  assign w_bitTick  = (r_clkCnt == CW'(CLKS_PER_BIT - 1));
  assign w_halfTick = (r_clkCnt == CW'(CLKS_PER_BIT / 2 - 1));

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // A start bit still high at its mid-point is treated as a glitch.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (r_rxPrev && !w_rx) w_nextState = START;
      START:   if (w_halfTick) w_nextState = w_rx ? IDLE : DATA;
      DATA:    if (w_bitTick && r_bitIdx == 3'd7) w_nextState = STOP;
      STOP:    if (w_bitTick) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxPrev <= 1'b1;
      r_clkCnt <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      r_sync1  <= rx_in;
      r_sync2  <= r_sync1;
      r_rxPrev <= w_rx;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_clkCnt <= '0;
          r_bitIdx <= '0;
        end
        START: r_clkCnt <= w_halfTick ? '0 : r_clkCnt + CW'(1);
        DATA: begin
          if (w_bitTick) begin
            r_clkCnt <= '0;
            r_shift  <= {w_rx, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 3'd1;
          end else begin
            r_clkCnt <= r_clkCnt + CW'(1);
          end
        end
        STOP: begin
          if (w_bitTick) begin
            r_clkCnt <= '0;
            if (w_rx) begin
              rx_byte  <= r_shift;
              rx_valid <= 1'b1;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            r_clkCnt <= r_clkCnt + CW'(1);
          end
        end
        default: r_clkCnt <= '0;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: receives a length-prefixed program image and writes it
// into memory from address 0, holding the CPU until the image is complete.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          UART_RX,
  uart_loader_if.master bus
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);

  loaderState_e          r_state;
  loaderState_e          w_nextState;
  logic [7:0]            w_rxByte;
  logic                  w_rxValid;
  logic                  w_rxFerr;
  logic [7:0]            r_lenHi;
  logic [7:0]            r_dataHi;
  logic [15:0]           r_remaining;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [DATA_WIDTH-1:0] r_memWdata;
  logic                  r_cpuHold;
  logic                  r_done;
  logic                  r_error;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) u_rx (
    .CLK      (CLK),
    .RST      (RST),
    .rx_in    (UART_RX),
    .rx_byte  (w_rxByte),
    .rx_valid (w_rxValid),
    .rx_ferr  (w_rxFerr)
  );

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_LEN_HI;
    else      r_state <= w_nextState;
  end

  // Framing errors abort the load from any state until the image is complete.
  always_comb begin
    w_nextState = r_state;
    if (w_rxFerr && r_state != S_DONE) begin
      w_nextState = S_ERROR;
    end else begin
      case (r_state)
        S_LEN_HI:  if (w_rxValid) w_nextState = S_LEN_LO;
        S_LEN_LO:  if (w_rxValid)
                     w_nextState = ({r_lenHi, w_rxByte} == 16'd0) ? S_DONE : S_DATA_HI;
        S_DATA_HI: if (w_rxValid) w_nextState = S_DATA_LO;
        S_DATA_LO: if (w_rxValid) w_nextState = S_WRITE;
        S_WRITE:   w_nextState = (r_remaining == 16'd1) ? S_DONE : S_DATA_HI;
        default:   w_nextState = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_lenHi     <= '0;
      r_dataHi    <= '0;
      r_remaining <= '0;
      r_index     <= '0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_cpuHold   <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done    <= (w_nextState == S_DONE);
      r_error   <= (w_nextState == S_ERROR);
      r_cpuHold <= (w_nextState != S_DONE);
      case (r_state)
        S_LEN_HI:  if (w_rxValid) r_lenHi <= w_rxByte;
        S_LEN_LO:  if (w_rxValid) r_remaining <= {r_lenHi, w_rxByte};
        S_DATA_HI: if (w_rxValid) r_dataHi <= w_rxByte;
        S_DATA_LO: begin
          if (w_rxValid) begin
            r_memAddr  <= r_index;
            r_memWdata <= {r_dataHi, w_rxByte};
          end
        end
        S_WRITE: begin
          r_index     <= r_index + ADDR_WIDTH'(1);
          r_remaining <= r_remaining - 16'd1;
        end
        default: r_index <= r_index;
      endcase
    end
  end

  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;
  assign bus.cpu_hold  = r_cpuHold;
  assign bus.done      = r_done;
  assign bus.error     = r_error;

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- UART boot loader upstream of the CPU core; receives a program image over a serial line and writes it word-by-word into instruction/data memory starting at address 0.
- Holds the CPU (cpu_hold=1) during reset and loading; releases it after the last word is written.
- Replaces simulation-only memory preloading on hardware.

Parameters:
- CLK_FREQ, 50000000, CLK frequency in Hz.
- BAUD, 115200, serial bit rate.
- ADDR_WIDTH, 16, memory address width; equals register width.
- DATA_WIDTH, 16, memory word width; equals instruction width. Fixed at 16; two bytes per word.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-low reset.
- UART_RX  in  1  asynchronous serial input; idle high.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  DATA_WIDTH  write data.
- cpu_hold  out  1  1 = CPU held (pc frozen at 0).
- done  out  1  sticky; load completed.
- error  out  1  sticky; framing error seen during load.

Behaviour:
- Reset (RST=0 at posedge CLK): mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, FSM=S_LEN_HI, RX=IDLE. Reset mid-load aborts the load; partial memory contents are left as-is.
- Clocking: CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated.
- UART_RX passes through a 2-flop synchronizer before use.
- RX framing: 8N1, LSB first.
  - A falling edge in IDLE starts a bit counter. The line is re-sampled at CLKS_PER_BIT/2.
  - If the line is high at the start-bit sample, it is a glitch: return to IDLE and emit no byte.
  - Data bits are sampled every CLKS_PER_BIT. The stop bit is sampled CLKS_PER_BIT later.
  - Stop=1: rx_valid pulses for 1 cycle with rx_byte.
  - Stop=0: rx_ferr pulses for 1 cycle and no byte is emitted.
  - RX returns to IDLE in the cycle after the stop sample.
- Protocol: the 2-byte word count N (big-endian) is followed by N words, each sent high byte first.
- Loader FSM:
  - S_LEN_HI: on rx_valid, latch count[15:8], go to S_LEN_LO.
  - S_LEN_LO: on rx_valid, latch count[7:0]. If the full count is 0: go to S_DONE. Otherwise go to S_DATA_HI.
  - S_DATA_HI: on rx_valid, latch hi byte, go to S_DATA_LO.
  - S_DATA_LO: on rx_valid, go to S_WRITE.
    - mem_wdata = {hi, rx_byte}.
    - mem_addr = word index.
  - S_WRITE: mem_we=1 for exactly this cycle, which is 1 clk after the low-byte rx_valid. Then:
    - increment index;
    - decrement remaining;
    - if remaining was 1, go to S_DONE; otherwise go to S_DATA_HI.
  - S_DONE: done=1, cpu_hold=0, both registered. They take effect in the cycle after entering S_DONE and remain until reset. All further RX bytes and framing errors are ignored.
  - S_ERROR: entered from any state except S_DONE on rx_ferr. error=1, cpu_hold stays 1, no further writes. Exit is by reset only.
- Address: starts at 0 and increments by 1 per word. N=2^ADDR_WIDTH-1 is the largest count. Wrap-around cannot occur because the count is 16 bits.
- rx_valid and the S_WRITE cycle never coincide (a byte takes ≥10·CLKS_PER_BIT cycles). No backpressure; the memory accepts a write every cycle.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Decomposition:
- Package uart_loader_pkg:
  - loader state enum (S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_DONE, S_ERROR);
  - RX state enum (IDLE, START, DATA, STOP);
  - function clks_per_bit(CLK_FREQ, BAUD).
- Sub-module uart_rx:
  - parameters CLKS_PER_BIT;
  - ports CLK, RST, rx_in, rx_byte[7:0], rx_valid, rx_ferr;
  - contains the synchronizer.
- uart_loader instantiates uart_rx and contains the loader FSM.

Test Plan (CLK_FREQ=1000000, BAUD=100000 → 10 clks/bit):
- Send 00 03 12 34 AB CD 0F F0 → 3 mem_we pulses: (0,1234), (1,ABCD), (2,0FF0). Each pulse is 1 clk after its low-byte stop sample. done=1 and cpu_hold=0 one cycle after the last write; error=0.
- Send 00 00 → no mem_we; done=1, cpu_hold=0. A following byte 55 causes no write and no change.
- Send 00 02 12 34, then a byte with stop bit=0 → exactly one write (0,1234); error=1, cpu_hold=1, done=0. A subsequent valid byte causes no write.
- Send a 3-clk low glitch on UART_RX while idle, then 00 01 BE EF → glitch ignored; single write (0,BEEF); done=1.
- Send 00 04 11 22, assert RST=0 for 1 clk, then send 00 01 33 44 → write (0,1122), then after reset a single write (0,3344); done=1. During reset cpu_hold=1 and mem_we=0.
